// File: rtl/canny_pkg.sv
// Shared types and timing constants for the Canny/Gaussian frame pipeline.
// Holds the frame-controller FSM encoding and the fixed read-to-write latency
// (one cycle memory read + one cycle input register in front of the filter).
package canny_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } frame_state_t;

  // Cycles from a source read strobe to the matching destination write.
  localparam int RD2WR_LAT = 2;

endpackage

// File: rtl/raster_counter.sv
// Raster-order row/col position counter for an IMG_W x IMG_H frame.
// Ports: clk, rst (sync, active-high), clr (restart at 0,0), inc (advance one
// pixel); row, col (current position), last (position is the final pixel).
module raster_counter #(
  parameter int IMG_W = 4,
  parameter int IMG_H = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       inc,
  output logic [$clog2(IMG_H)-1:0]   row,
  output logic [$clog2(IMG_W)-1:0]   col,
  output logic                       last
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  logic col_end;
  logic row_end;

  assign col_end = (col == CW'(IMG_W - 1));
  assign row_end = (row == RW'(IMG_H - 1));
  assign last    = col_end && row_end;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      row <= '0;
      col <= '0;
    end else if (inc) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gaussian_frame_ctrl.sv
// Frame sequencer for a streaming Gaussian filter: clears the filter, reads
// the source frame in raster order, feeds the filter and writes the result.
// Ports: start/busy/done handshake; rd_* source memory; filt_* filter stream;
// wr_* destination memory with wr_border flagging frame-edge pixels.
module gaussian_frame_ctrl
  import canny_pkg::*;
#(
  parameter int IMG_W       = 4,
  parameter int IMG_H       = 3,
  parameter int ADDR_W      = 16,
  parameter int BORDER_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              filt_clr,
  output logic [7:0]        filt_din,
  input  logic [7:0]        filt_dout,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              wr_border
);

  localparam int N  = IMG_W * IMG_H;
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  frame_state_t          state, state_nxt;
  logic [ADDR_W-1:0]     rd_cnt;
  logic                  rd_last;
  logic [RD2WR_LAT-1:0]  vld_sr;
  logic [ADDR_W-1:0]     addr_sr [RD2WR_LAT];
  logic [RW-1:0]         wr_row;
  logic [CW-1:0]         wr_col;
  logic                  wr_last;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Outputs decode from the state register only, so nothing on the input
  // side reaches rd_en/wr_en combinationally.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    filt_clr  = 1'b0;
    rd_en     = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_CLEAR;
      ST_CLEAR: begin
        busy      = 1'b1;
        filt_clr  = 1'b1;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy  = 1'b1;
        rd_en = 1'b1;
        if (rd_last) state_nxt = ST_DRAIN;
      end
      // The pipeline empties exactly when the final pixel is written, which
      // is the second drain cycle.
      ST_DRAIN: begin
        busy = 1'b1;
        if (wr_en && wr_last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign rd_last = (rd_cnt == ADDR_W'(N - 1));
  assign rd_addr = rd_en ? rd_cnt : '0;

  always_ff @(posedge clk) begin
    if (rst) rd_cnt <= '0;
    else if (state == ST_RUN && !rd_last) rd_cnt <= rd_cnt + 1'b1;
    else rd_cnt <= '0;
  end

  // Read-to-write delay line. rd_addr is already zero when idle, so the
  // delayed address is zero on every non-write cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr   <= '0;
      filt_din <= '0;
      for (int i = 0; i < RD2WR_LAT; i++) addr_sr[i] <= '0;
    end else begin
      vld_sr     <= {vld_sr[RD2WR_LAT-2:0], rd_en};
      addr_sr[0] <= rd_addr;
      for (int i = 1; i < RD2WR_LAT; i++) addr_sr[i] <= addr_sr[i-1];
      // rd_data is valid the cycle after a read strobe.
      filt_din   <= vld_sr[0] ? rd_data : 8'h00;
    end
  end

  assign wr_en   = vld_sr[RD2WR_LAT-1];
  assign wr_addr = wr_en ? addr_sr[RD2WR_LAT-1] : '0;

  raster_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_wr_pos (
    .clk  (clk),
    .rst  (rst),
    .clr  (filt_clr),
    .inc  (wr_en),
    .row  (wr_row),
    .col  (wr_col),
    .last (wr_last)
  );

  assign wr_border = wr_en && ((wr_row == '0) || (wr_row == RW'(IMG_H - 1)) ||
                               (wr_col == '0) || (wr_col == CW'(IMG_W - 1)));

  assign wr_data = (!wr_en || ((BORDER_ZERO != 0) && wr_border)) ? 8'h00 : filt_dout;

endmodule

// File: tb/tb_gaussian_frame_ctrl.sv
module tb_gaussian_frame_ctrl;
  import canny_pkg::*;

  typedef struct {
    int addr;
    int data;
    int border;
    int rd_rel;
  } exp_t;

  logic clk = 1'b0;
  logic rst, start;
  logic filt_mode;  // 1: filter stub returns 0xAA, 0: passthrough

  logic        busy0, done0, rd_en0, filt_clr0, wr_en0, wr_border0;
  logic [15:0] rd_addr0, wr_addr0;
  logic [7:0]  rd_data0, filt_din0, filt_dout0, wr_data0;
  logic        busy1, done1, rd_en1, filt_clr1, wr_en1, wr_border1;
  logic [15:0] rd_addr1, wr_addr1;
  logic [7:0]  rd_data1, filt_din1, filt_dout1, wr_data1;

  int n_chk = 0, n_err = 0;
  int cyc = 0, t0 = 0, rel;
  int rd_exp = 0;
  exp_t q0[$], q1[$];
  exp_t e0, e1;
  int clr_cyc[$], done_cyc[$];
  int rd_n, wr_n, wr1_n, border_n, border1_n, aa_n, busy_n, idle_bad;
  int first_busy, first_rd, last_rd, first_wr, last_wr;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  gaussian_frame_ctrl #(.IMG_W(4), .IMG_H(3), .ADDR_W(16), .BORDER_ZERO(1)) dut0 (
    .clk(clk), .rst(rst), .start(start), .busy(busy0), .done(done0),
    .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_data(rd_data0),
    .filt_clr(filt_clr0), .filt_din(filt_din0), .filt_dout(filt_dout0),
    .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0), .wr_border(wr_border0));

  gaussian_frame_ctrl #(.IMG_W(4), .IMG_H(3), .ADDR_W(16), .BORDER_ZERO(0)) dut1 (
    .clk(clk), .rst(rst), .start(start), .busy(busy1), .done(done1),
    .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .filt_clr(filt_clr1), .filt_din(filt_din1), .filt_dout(filt_dout1),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1), .wr_border(wr_border1));

  // Source memory: pixel k holds k*10, one cycle read latency.
  always @(posedge clk) begin
    rd_data0 <= rd_en0 ? 8'(rd_addr0 * 10) : 8'h00;
    rd_data1 <= rd_en1 ? 8'(rd_addr1 * 10) : 8'h00;
  end
  assign filt_dout0 = filt_mode ? 8'hAA : filt_din0;
  assign filt_dout1 = filt_mode ? 8'hAA : filt_din1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int is_border(input int a);
    int r, c;
    r = a / 4;
    c = a % 4;
    return (r == 0 || r == 2 || c == 0 || c == 3) ? 1 : 0;
  endfunction

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic reset_stats();
    clr_cyc.delete(); done_cyc.delete();
    rd_n = 0; wr_n = 0; wr1_n = 0; border_n = 0; border1_n = 0; aa_n = 0;
    busy_n = 0; idle_bad = 0;
    first_busy = -1; first_rd = -1; last_rd = -1; first_wr = -1; last_wr = -1;
  endtask

  // Scoreboard: every read pushes the write it must produce two cycles later.
  always @(negedge clk) begin
    rel = cyc - t0;
    if (rd_en0) begin
      check("rd_addr", 32'(rd_addr0), 32'(rd_exp));
      e0.addr = rd_exp;
      e0.border = is_border(rd_exp);
      e0.data = e0.border ? 0 : (filt_mode ? 32'hAA : rd_exp * 10);
      e0.rd_rel = rel;
      q0.push_back(e0);
      e1.addr = rd_exp;
      e1.border = e0.border;
      e1.data = filt_mode ? 32'hAA : rd_exp * 10;
      e1.rd_rel = rel;
      if (rd_en1) q1.push_back(e1);
      rd_exp = (rd_exp + 1) % 12;
      rd_n++;
      if (first_rd < 0) first_rd = rel;
      last_rd = rel;
    end else if (rd_addr0 !== 16'h0) idle_bad++;
    if (wr_en0) begin
      wr_n++;
      if (first_wr < 0) first_wr = rel;
      last_wr = rel;
      if (wr_border0) border_n++;
      if (wr_data0 == 8'hAA) aa_n++;
      if (q0.size() == 0) check("wr0_unexpected", 1, 0);
      else begin
        e0 = q0.pop_front();
        check("wr0_addr", 32'(wr_addr0), 32'(e0.addr));
        check("wr0_data", 32'(wr_data0), 32'(e0.data));
        check("wr0_border", 32'(wr_border0), 32'(e0.border));
        check("wr0_latency", 32'(rel), 32'(e0.rd_rel + 2));
      end
    end else if (wr_addr0 !== 16'h0 || wr_border0 !== 1'b0 || wr_data0 !== 8'h00) idle_bad++;
    if (wr_en1) begin
      wr1_n++;
      if (wr_border1) border1_n++;
      if (q1.size() == 0) check("wr1_unexpected", 1, 0);
      else begin
        e1 = q1.pop_front();
        check("wr1_addr", 32'(wr_addr1), 32'(e1.addr));
        check("wr1_data", 32'(wr_data1), 32'(e1.data));
        check("wr1_border", 32'(wr_border1), 32'(e1.border));
      end
    end
    if (filt_clr0) clr_cyc.push_back(rel);
    if (done0) done_cyc.push_back(rel);
    if (busy0) begin
      busy_n++;
      if (first_busy < 0) first_busy = rel;
    end
  end

  task automatic check_quiet(input string pfx);
    check({pfx, "_busy"}, 32'(busy0), 0);
    check({pfx, "_done"}, 32'(done0), 0);
    check({pfx, "_rd_en"}, 32'(rd_en0), 0);
    check({pfx, "_rd_addr"}, 32'(rd_addr0), 0);
    check({pfx, "_filt_clr"}, 32'(filt_clr0), 0);
    check({pfx, "_filt_din"}, 32'(filt_din0), 0);
    check({pfx, "_wr_en"}, 32'(wr_en0), 0);
    check({pfx, "_wr_addr"}, 32'(wr_addr0), 0);
    check({pfx, "_wr_data"}, 32'(wr_data0), 0);
    check({pfx, "_wr_border"}, 32'(wr_border0), 0);
    check({pfx, "_state"}, 32'(dut0.state), 32'(ST_IDLE));
  endtask

  task automatic start_pulse();
    @(posedge clk); #1;
    t0 = cyc;
    reset_stats();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic check_frame(input string pfx);
    check({pfx, "_clr_cnt"}, 32'(clr_cyc.size()), 1);
    check({pfx, "_clr_cyc"}, 32'(qget(clr_cyc, 0)), 1);
    check({pfx, "_first_busy"}, 32'(first_busy), 1);
    check({pfx, "_busy_cnt"}, 32'(busy_n), 15);
    check({pfx, "_first_rd"}, 32'(first_rd), 2);
    check({pfx, "_last_rd"}, 32'(last_rd), 13);
    check({pfx, "_rd_cnt"}, 32'(rd_n), 12);
    check({pfx, "_first_wr"}, 32'(first_wr), 4);
    check({pfx, "_last_wr"}, 32'(last_wr), 15);
    check({pfx, "_wr_cnt"}, 32'(wr_n), 12);
    check({pfx, "_wr1_cnt"}, 32'(wr1_n), 12);
    check({pfx, "_done_cnt"}, 32'(done_cyc.size()), 1);
    check({pfx, "_done_cyc"}, 32'(qget(done_cyc, 0)), 16);
    check({pfx, "_border_cnt"}, 32'(border_n), 10);
    check({pfx, "_border1_cnt"}, 32'(border1_n), 10);
    check({pfx, "_q_left"}, 32'(q0.size() + q1.size()), 0);
    check({pfx, "_idle_outputs"}, 32'(idle_bad), 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    filt_mode = 1'b1;
    reset_stats();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Nominal frame, constant 0xAA filter: only interior pixels 5 and 6 keep it.
    start_pulse();
    repeat (25) @(posedge clk); #1;
    check_frame("nominal");
    check("nominal_aa_cnt", 32'(aa_n), 2);

    // Passthrough filter: scoreboard checks data k*10 on both instances.
    filt_mode = 1'b0;
    start_pulse();
    repeat (25) @(posedge clk); #1;
    check_frame("pass");
    check("pass_aa_cnt", 32'(aa_n), 0);

    // Mid-frame reset at cycle 8, restart at cycle 12.
    start_pulse();
    repeat (7) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_quiet("abort");
    #1;
    q0.delete(); q1.delete();
    rd_exp = 0;
    reset_stats();
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_no_wr", 32'(wr_n), 0);
    check("abort_no_done", 32'(done_cyc.size()), 0);
    start_pulse();
    repeat (25) @(posedge clk); #1;
    check_frame("restart");

    // start held across cycles 0-30: two back-to-back frames.
    @(posedge clk); #1;
    t0 = cyc;
    reset_stats();
    start = 1'b1;
    repeat (31) @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk); #1;
    check("held_wr_cnt", 32'(wr_n), 24);
    check("held_done_cnt", 32'(done_cyc.size()), 2);
    check("held_done0", 32'(qget(done_cyc, 0)), 16);
    check("held_done1", 32'(qget(done_cyc, 1)), 33);
    check("held_clr_cnt", 32'(clr_cyc.size()), 2);
    check("held_clr1", 32'(qget(clr_cyc, 1)), 18);
    check("held_busy_cnt", 32'(busy_n), 30);
    check("held_q_left", 32'(q0.size() + q1.size()), 0);

    // rst and start together: reset wins.
    @(posedge clk); #1;
    t0 = cyc;
    reset_stats();
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    repeat (5) @(posedge clk); #1;
    check("rst_start_busy", 32'(busy_n), 0);
    check("rst_start_rd", 32'(rd_n), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/gaussian_frame_ctrl.md
GAUSSIAN_FRAME_CTRL -- requirements
Module: gaussian_frame_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 4, image width in pixels (>=3).
REQ-002 SHALL have parameter IMG_H, default 3, image height in pixels (>=3).
REQ-003 SHALL have parameter ADDR_W, default 16, pixel address width; IMG_W*IMG_H <= 2**ADDR_W.
REQ-004 SHALL have parameter BORDER_ZERO, default 1, 1 = force border output pixels to 0.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  frame request; sampled only in IDLE.
REQ-008 busy  out  1  frame in progress.
REQ-009 done  out  1  one-cycle pulse at frame end.
REQ-010 rd_en  out  1  source pixel memory read strobe.
REQ-011 rd_addr  out  ADDR_W  source read address, raster order.
REQ-012 rd_data  in  8  source pixel, valid 1 cycle after rd_en.
REQ-013 filt_clr  out  1  reset/flush pulse to the Gaussian filter.
REQ-014 filt_din  out  8  pixel stream to filter input.
REQ-015 filt_dout  in  8  filtered pixel from filter.
REQ-016 wr_en  out  1  destination memory write strobe.
REQ-017 wr_addr  out  ADDR_W  destination write address.
REQ-018 wr_data  out  8  destination write data.
REQ-019 wr_border  out  1  current write is a border pixel (row 0, row IMG_H-1, col 0, col IMG_W-1).

Function
REQ-020 SHALL implement FSM states IDLE, CLEAR, RUN, DRAIN, DONE.
REQ-021 IDLE -> CLEAR on start=1; start ignored in all other states.
REQ-022 CLEAR SHALL last exactly 1 cycle with filt_clr=1; filt_clr=0 in all other states.
REQ-023 RUN SHALL last exactly N=IMG_W*IMG_H cycles, rd_en=1, rd_addr = 0,1,...,N-1 on consecutive cycles.
REQ-024 RUN -> DRAIN after read of address N-1; DRAIN SHALL last exactly 2 cycles.
REQ-025 DRAIN -> DONE; DONE SHALL last 1 cycle with done=1, then -> IDLE.
REQ-026 busy SHALL be 1 in CLEAR, RUN, DRAIN; 0 in IDLE and DONE.
REQ-027 filt_din SHALL equal rd_data registered once (filter sees pixel k 2 cycles after read k); filt_din = 0 outside RUN/DRAIN.
REQ-028 Write for pixel k SHALL occur exactly 2 cycles after read of pixel k: wr_en=1 on last N-2 RUN cycles and both DRAIN cycles, exactly N writes per frame.
REQ-029 wr_addr SHALL be the read address delayed 2 cycles (0..N-1, no wrap, no skip).
REQ-030 wr_data = 0 when BORDER_ZERO=1 and wr_border=1; otherwise wr_data = filt_dout.
REQ-031 Row/col for wr_border SHALL come from write-side col (0..IMG_W-1) and row (0..IMG_H-1) counters; col wraps to 0 and row increments at col=IMG_W-1.
REQ-032 wr_border, wr_addr SHALL be 0 whenever wr_en=0; rd_addr SHALL be 0 whenever rd_en=0.
REQ-033 start=1 held through DONE SHALL NOT retrigger until the FSM is back in IDLE (earliest next CLEAR is cycle after IDLE entry sample).

Reset
REQ-034 rst=1 at any cycle, including mid-frame, SHALL on the next edge force IDLE, all counters 0, and busy, done, rd_en, rd_addr, filt_clr, filt_din, wr_en, wr_addr, wr_data, wr_border to 0.
REQ-035 An aborted frame SHALL produce no further writes and no done pulse.
REQ-036 rst=1 and start=1 on the same edge: reset wins.

Structure
REQ-037 FSM state enum and the fixed 2-cycle read-to-write latency constant SHALL live in shared package canny_pkg.
REQ-038 Raster row/col counter SHALL be a sub-module raster_counter (params IMG_W, IMG_H; inputs clk, rst, clr, inc; outputs row, col, last), instantiated once for write side.
REQ-039 Target size 120-400 lines RTL; no combinational path from any input to rd_en/wr_en.

Verification (IMG_W=4, IMG_H=3, N=12, BORDER_ZERO=1, start at cycle 0)
REQ-040 Nominal frame: CLEAR cycle 1; rd_en cycles 2-13 addr 0-11; wr_en cycles 4-15 addr 0-11; done only cycle 16; busy cycles 1-15.
REQ-041 Border masking: filter returns 0xAA constant -> wr_data 0xAA only at addr 5 and 6, 0x00 at other 10 addrs, wr_border=1 at those 10.
REQ-042 BORDER_ZERO=0, rd_data = addr*10 passthrough filter stub -> wr_data at addr k equals k*10 for all k, wr_border still flags 10 pixels.
REQ-043 rst=1 at cycle 8 -> cycle 9: all outputs 0, state IDLE; no wr_en, no done afterwards; new start at cycle 12 gives full 12-write frame.
REQ-044 start held high cycles 0-30 -> two back-to-back frames, second CLEAR at cycle 18, no overlap, 24 writes total, two done pulses.
REQ-045 start and rst both 1 at cycle 0 -> busy stays 0, no rd_en.
